b_legal_scan: RTL

Legal-move scanner for the Othello datapath. Given the red/blue bitboards and the side to move, it computes the full 64-bit legal-move mask over eight clocked direction passes. It also reports the move count and the lowest-index legal square. It sits directly upstream of `b_move`: its X/Y output feeds `b_move`'s X/Y, and its `valid` output tells the controller whether the side must pass.

---
 rtl/b_legal_scan_if.sv | 25 ++
 rtl/b_legal_scan.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/b_legal_scan_if.sv
// Bus between the Othello controller and the legal-move scanner.
// Request side carries the boards and side to move; response side carries the scan result.
interface b_legal_scan_if;
    logic        start;
    logic        player;
    logic [63:0] R_;
    logic [63:0] B_;
    logic [63:0] MOVES;
    logic [6:0]  CNT;
    logic [2:0]  X;
    logic [2:0]  Y;
    logic        valid;
    logic        busy;
    logic        done;

    modport master (
        output start, player, R_, B_,
        input  MOVES, CNT, X, Y, valid, busy, done
    );

    modport slave (
        input  start, player, R_, B_,
        output MOVES, CNT, X, Y, valid, busy, done
    );
endinterface

// File: rtl/b_legal_scan.sv
// Othello legal-move scanner: one flood-fill direction per clock over eight cycles, then
// registers the move mask, its popcount and the lowest-index legal square.
module b_legal_scan (
    input logic          clk,
    input logic          RST,
    b_legal_scan_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    localparam logic [63:0] NotColZero  = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [63:0] NotColSeven = 64'h7F7F_7F7F_7F7F_7F7F;

    state_e      state_q, state_d;
    logic [2:0]  dir_q, dir_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] r_q, r_d;
    logic [63:0] b_q, b_d;
    logic        player_q, player_d;
    logic [63:0] moves_q, moves_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [2:0]  x_q, x_d;
    logic [2:0]  y_q, y_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;

    logic [63:0] own, opp, empty;
    logic [63:0] run;
    logic [63:0] acc_next;
    logic [6:0]  acc_pop;
    logic [5:0]  acc_low;

    // Shift one step in direction d; column masks stop runs wrapping across row edges.
    function automatic logic [63:0] step(input logic [63:0] v, input logic [2:0] d);
        logic [63:0] r;
        unique case (d)
            3'd0:    r = (v << 1) & NotColZero;
            3'd1:    r = (v >> 1) & NotColSeven;
            3'd2:    r = v << 8;
            3'd3:    r = v >> 8;
            3'd4:    r = (v << 9) & NotColZero;
            3'd5:    r = (v << 7) & NotColSeven;
            3'd6:    r = (v >> 7) & NotColZero;
            default: r = (v >> 9) & NotColSeven;
        endcase
        return r;
    endfunction

    // Flood fill over opponent discs from own discs, then land on an empty square.
    always_comb begin
        own   = player_q ? r_q : b_q;
        opp   = player_q ? b_q : r_q;
        empty = ~(r_q | b_q);
        run   = step(own, dir_q) & opp;
        for (int k = 0; k < 5; k++) begin
            run = run | (step(run, dir_q) & opp);
        end
        acc_next = acc_q | (step(run, dir_q) & empty);
    end

    always_comb begin
        acc_pop = '0;
        acc_low = '0;
        for (int i = 0; i < 64; i++) begin
            acc_pop = acc_pop + {6'd0, acc_next[i]};
        end
        // Walk downward so the lowest set bit wins.
        for (int i = 63; i >= 0; i--) begin
            if (acc_next[i]) begin
                acc_low = 6'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q  <= StIdle;
            dir_q    <= '0;
            acc_q    <= '0;
            r_q      <= '0;
            b_q      <= '0;
            player_q <= 1'b0;
            moves_q  <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            acc_q    <= acc_d;
            r_q      <= r_d;
            b_q      <= b_d;
            player_q <= player_d;
            moves_q  <= moves_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        acc_d    = acc_q;
        r_d      = r_q;
        b_d      = b_q;
        player_d = player_q;
        moves_d  = moves_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    r_d      = bus.R_;
                    b_d      = bus.B_;
                    player_d = bus.player;
                    acc_d    = '0;
                    dir_d    = '0;
                    state_d  = StScan;
                end
            end
            StScan: begin
                acc_d = acc_next;
                dir_d = dir_q + 3'd1;
                if (dir_q == 3'd7) begin
                    state_d = StIdle;
                    moves_d = acc_next;
                    cnt_d   = acc_pop;
                    x_d     = acc_low[2:0];
                    y_d     = acc_low[5:3];
                    valid_d = (acc_next != '0);
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.MOVES = moves_q;
    assign bus.CNT   = cnt_q;
    assign bus.X     = x_q;
    assign bus.Y     = y_q;
    assign bus.valid = valid_q;
    assign bus.busy  = (state_q == StScan);
    assign bus.done  = done_q;

endmodule
